// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module   : if_stage_pkg
// Brief    : Shared widths, reset PC and bus layouts for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

  localparam int          FS_TO_DS_BUS_WD = 64;
  localparam int          BR_BUS_WD       = 33;
  localparam logic [31:0] RESET_PC        = 32'h1c00_0000;
  localparam logic [1:0]  SRAM_SIZE_WORD  = 2'b10;
  localparam logic [31:0] INST_BYTES      = 32'd4;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_bus_t;

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
// ============================================================================
// Module   : if_stage_if
// Brief    : Decode-side, branch and instruction-SRAM signals of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_if;
  import if_stage_pkg::*;

  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

  logic                       inst_sram_req;
  logic                       inst_sram_wr;
  logic [1:0]                 inst_sram_size;
  logic [3:0]                 inst_sram_wstrb;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;
  logic                       inst_sram_addr_ok;
  logic                       inst_sram_data_ok;
  logic [31:0]                inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    output inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    input  inst_sram_addr, inst_sram_wdata
  );

endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch with one outstanding SRAM request, branch
//            redirect buffer and a single-entry fetch register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  if_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_npc;
  logic [31:0]   r_addr;
  logic          r_cancel;
  logic          r_br_buf_valid;
  logic [31:0]   r_br_buf_target;
  logic          r_fs_valid;
  logic [31:0]   r_fs_pc;
  logic [31:0]   r_fs_inst;

  br_bus_t       w_br;
  fs_to_ds_bus_t w_fs_bus;
  logic          w_fs_free;
  logic          w_issue;
  logic [31:0]   w_issue_addr;
  logic          w_req;
  logic [31:0]   w_sram_addr;
  logic          w_accept;
  logic          w_redirect_pending;
  logic          w_data_ok;
  logic          w_fs_to_ds_valid;
  logic          w_handoff;

  assign w_br = br_bus_t'(bus.br_bus);

  // A new fetch may start only if the fetch register is empty by the time data returns.
  assign w_fs_free          = !r_fs_valid || bus.ds_allowin;
  assign w_issue            = (r_state == S_IDLE) && w_fs_free;
  assign w_issue_addr       = r_br_buf_valid ? r_br_buf_target : r_npc;
  assign w_req              = resetn && ((r_state == S_REQ) || w_issue);
  assign w_sram_addr        = (r_state == S_IDLE) ? w_issue_addr : r_addr;
  assign w_accept           = w_req && bus.inst_sram_addr_ok;
  assign w_redirect_pending = (r_state == S_REQ) && r_br_buf_valid;
  assign w_data_ok          = (r_state == S_WAIT) && bus.inst_sram_data_ok;
  assign w_fs_to_ds_valid   = r_fs_valid && !w_br.taken;
  assign w_handoff          = w_fs_to_ds_valid && bus.ds_allowin;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_npc           <= RESET_PC;
      r_addr          <= RESET_PC;
      r_cancel        <= 1'b0;
      r_br_buf_valid  <= 1'b0;
      r_br_buf_target <= '0;
      r_fs_valid      <= 1'b0;
      r_fs_pc         <= '0;
      r_fs_inst       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_addr <= w_issue_addr;
            if (bus.inst_sram_addr_ok) begin
              r_state  <= S_WAIT;
              r_cancel <= w_br.taken;
            end else begin
              r_state  <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A redirect parked while this request stalled makes it wrong-path.
          if (bus.inst_sram_addr_ok) begin
            r_state  <= S_WAIT;
            r_cancel <= w_br.taken || r_br_buf_valid;
          end
        end
        S_WAIT: begin
          if (bus.inst_sram_data_ok) begin
            r_state  <= S_IDLE;
            r_cancel <= 1'b0;
          end else if (w_br.taken) begin
            r_cancel <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_br.taken) begin
        r_npc <= w_br.target;
      end else if (w_accept && !w_redirect_pending) begin
        r_npc <= w_sram_addr + INST_BYTES;
      end

      // The request on the bus cannot change until accepted, so the target waits here.
      if (w_br.taken && w_req && !bus.inst_sram_addr_ok) begin
        r_br_buf_valid  <= 1'b1;
        r_br_buf_target <= w_br.target;
      end else if (w_br.taken || w_issue) begin
        r_br_buf_valid  <= 1'b0;
      end

      if (w_br.taken) begin
        r_fs_valid <= 1'b0;
      end else if (w_data_ok && !r_cancel) begin
        r_fs_valid <= 1'b1;
        r_fs_pc    <= r_addr;
        r_fs_inst  <= bus.inst_sram_rdata;
      end else if (w_handoff) begin
        r_fs_valid <= 1'b0;
      end
    end
  end

  assign w_fs_bus = '{pc: r_fs_pc, inst: r_fs_inst};

  assign bus.fs_to_ds_valid  = w_fs_to_ds_valid;
  assign bus.fs_to_ds_bus    = w_fs_bus;
  assign bus.inst_sram_req   = w_req;
  assign bus.inst_sram_addr  = w_sram_addr;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = SRAM_SIZE_WORD;
  assign bus.inst_sram_wstrb = 4'b0;
  assign bus.inst_sram_wdata = 32'b0;

endmodule

`default_nettype wire
